// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the I/D-cache memory bus arbiter: FSM states, grant IDs
// and the saturating event counter helper.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_I  = 2'd1;
    localparam logic [1:0] ST_BUSY_D  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_pick2.sv
// Combinational two-way picker: decides whether the D-cache wins this grant.
module arb_pick2 import mem_bus_arbiter_pkg::*; #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_d,
    output logic any_req
);

    assign any_req = req_i | req_d;

    // On contention D wins when priority is fixed, or when I was served last.
    assign grant_d = req_d & (~req_i | (ROUND_ROBIN == 0) | (last_grant == GNT_I));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one main-memory port between I-cache and D-cache; one registered
// access at a time, with a dead RELEASE cycle after every completion.
module mem_bus_arbiter import mem_bus_arbiter_pkg::*; #(
    parameter int ADDR_W      = 28,
    parameter int DATA_W      = 128,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       cnt_i,
    output logic [15:0]       cnt_d
);

    logic [1:0] state;
    logic       last_grant;
    logic       grant_d;
    logic       any_req;

    arb_pick2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
        .req_i      (i_read),
        .req_d      (d_read | d_write),
        .last_grant (last_grant),
        .grant_d    (grant_d),
        .any_req    (any_req)
    );

    // NOTE: ready is gated by rst so a reset that coincides with mem_ready
    // abandons the access instead of reporting it complete.
    assign i_ready = !rst && (state == ST_BUSY_I) && mem_ready;
    assign d_ready = !rst && (state == ST_BUSY_D) && mem_ready;
    assign i_rdata = i_ready ? mem_rdata : '0;
    assign d_rdata = d_ready ? mem_rdata : '0;

    // NOTE: non-blocking assignments throughout, so every register in this
    // block samples the values present before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= GNT_I;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            // NOTE: the wide address/data registers are reset as well because
            // the memory side is defined to read all-zero out of reset.
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cnt_i      <= '0;
            cnt_d      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        mem_write <= grant_d & d_write;
                        mem_read  <= ~grant_d | ~d_write;
                        state     <= grant_d ? ST_BUSY_D : ST_BUSY_I;
                    end
                end
                ST_BUSY_I: begin
                    if (mem_ready) begin
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        last_grant <= GNT_I;
                        cnt_i      <= sat_inc(cnt_i);
                        state      <= ST_RELEASE;
                    end
                end
                ST_BUSY_D: begin
                    if (mem_ready) begin
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        last_grant <= GNT_D;
                        cnt_d      <= sat_inc(cnt_d);
                        state      <= ST_RELEASE;
                    end
                end
                // RELEASE: one dead cycle so requesters can drop their strobes.
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
